// File: rtl/tau_result_drain.sv
// Snapshots the DIM x DIM MAC result on capture and streams it out one row per valid/ready handshake, row 0 first.
// Latency: capture in cycle N -> row 0 valid in cycle N+1; one row per cycle with out_ready held high.
// Backpressure: row held stable while out_ready=0; capture during a stream is dropped (sticky overflow) unless it lands on the last-row handshake.
// Optional: define TAU_DRAIN_REQUANT_EN for per-element right-shift + saturation to OUT_WIDTH bits.
module tau_result_drain #(
    parameter int DIM        = 16,
    parameter int IN_BITS    = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT_BITS = 5,
`ifdef TAU_DRAIN_REQUANT_EN
    localparam int EW        = OUT_WIDTH,
`else
    localparam int EW        = IN_BITS,
`endif
    localparam int RW        = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         capture,
    input  logic [DIM*DIM*IN_BITS-1:0]   in_mat,
    input  logic [SHIFT_BITS-1:0]        shift_amt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DIM*EW-1:0]            out_data,
    output logic [RW-1:0]                out_row,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overflow,
    input  logic                         overflow_clr
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DIM-1:0][DIM-1:0][IN_BITS-1:0] r_buf;
    logic [RW-1:0]                        r_row;
    logic                                 r_ovf;

    logic                                 w_hs;
    logic                                 w_last;
    logic                                 w_accept;
    logic                                 w_drop;
    logic [DIM-1:0][IN_BITS-1:0]          w_row;

    assign w_hs   = (r_state == STREAM) && out_ready;
    assign w_last = (r_row == RW'(DIM - 1));

    // A capture is taken when idle, or when it coincides with the final row leaving (zero-bubble chaining).
    assign w_accept = capture && ((r_state == IDLE) || (w_hs && w_last));
    assign w_drop   = capture && (r_state == STREAM) && !(w_hs && w_last);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave STREAM only after the last row drains with no chained capture.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (capture) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_hs && w_last && !capture) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef TAU_DRAIN_REQUANT_EN
    logic [SHIFT_BITS-1:0]       r_shift;
    logic [DIM-1:0][EW-1:0]      w_q;
    logic [DIM-1:0][IN_BITS-1:0] w_sh;
    localparam logic [OUT_WIDTH-1:0] SAT_O = '1;

    // Snapshot buffer, latched shift and row counter; row returns to 0 once a job finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf   <= '0;
            r_row   <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            r_buf   <= in_mat;
            r_row   <= '0;
            r_shift <= shift_amt;
        end else if (w_hs) begin
            r_row   <= w_last ? '0 : r_row + RW'(1);
        end
    end

    // Requantize the selected row: shift right, saturate to OUT_WIDTH; oversize shifts give 0.
    always_comb begin
        w_q  = '0;
        w_sh = '0;
        for (int c = 0; c < DIM; c++) begin
            if (r_shift >= SHIFT_BITS'(IN_BITS)) begin
                w_sh[c] = '0;
            end else begin
                w_sh[c] = w_row[c] >> r_shift;
            end
            if (w_sh[c] > IN_BITS'(SAT_O)) begin
                w_q[c] = SAT_O;
            end else begin
                w_q[c] = w_sh[c][OUT_WIDTH-1:0];
            end
        end
    end

    assign out_data = w_q;
`else
    logic [1:0] w_unused_cfg;

    // Snapshot buffer and row counter; row returns to 0 once a job finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_buf <= in_mat;
            r_row <= '0;
        end else if (w_hs) begin
            r_row <= w_last ? '0 : r_row + RW'(1);
        end
    end

    // Shift amount and output width have no role without requantization.
    assign w_unused_cfg = {^shift_amt, (OUT_WIDTH > 0)};
    assign out_data     = w_row;
`endif

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (overflow_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_row     = r_buf[r_row];
    assign out_valid = (r_state == STREAM);
    assign busy      = (r_state == STREAM);
    assign out_row   = r_row;
    assign out_last  = (r_state == STREAM) && w_last;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_tau_result_drain.sv
// Scoreboard bench for tau_result_drain at DIM=4: stimulus pushes expected rows and status probes,
// a negedge monitor pops and compares them whenever the DUT hands off a row or a probe is pending.
// Inputs change 1ns after the rising edge; all sampling happens on the falling edge.
module tb_tau_result_drain;
    localparam int DIM        = 4;
    localparam int IN_BITS    = 16;
    localparam int OUT_WIDTH  = 8;
    localparam int SHIFT_BITS = 5;
`ifdef TAU_DRAIN_REQUANT_EN
    localparam int EW = OUT_WIDTH;
`else
    localparam int EW = IN_BITS;
`endif
    localparam int RW = 2;

    logic                                 clk;
    logic                                 reset;
    logic                                 capture;
    logic [DIM-1:0][DIM-1:0][IN_BITS-1:0] mat;
    logic [SHIFT_BITS-1:0]                shift_amt;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [DIM*EW-1:0]                    out_data;
    logic [RW-1:0]                        out_row;
    logic                                 out_last;
    logic                                 busy;
    logic                                 overflow;
    logic                                 overflow_clr;

    tau_result_drain #(
        .DIM(DIM), .IN_BITS(IN_BITS), .OUT_WIDTH(OUT_WIDTH), .SHIFT_BITS(SHIFT_BITS)
    ) dut (
        .clk(clk), .reset(reset), .capture(capture), .in_mat(mat), .shift_amt(shift_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .busy(busy), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DIM*EW-1:0] d;
        logic [RW-1:0]     row;
        logic              last;
    } row_t;

    typedef struct packed {
        logic              vld;
        logic              bsy;
        logic              last;
        logic              ovf;
        logic              chk_d;
        logic [RW-1:0]     row;
        logic [DIM*EW-1:0] d;
    } probe_t;

    row_t   sb_q[$];
    probe_t pr_q[$];
    string  pn_q[$];

    int errors = 0;
    int checks = 0;
    bit done_req = 1'b0;
    bit mon_done = 1'b0;

    function automatic logic [DIM*EW-1:0] pack4(input logic [IN_BITS-1:0] e0, e1, e2, e3);
        return {EW'(e3), EW'(e2), EW'(e1), EW'(e0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [DIM*EW-1:0] d, input int r);
        row_t e;
        e.d    = d;
        e.row  = RW'(r);
        e.last = (r == DIM - 1);
        sb_q.push_back(e);
    endtask

    task automatic probe(input string nm, input bit v, input bit b, input int r, input bit l,
                         input bit o, input bit cd, input logic [DIM*EW-1:0] d);
        probe_t p;
        p.vld   = v;
        p.bsy   = b;
        p.row   = RW'(r);
        p.last  = l;
        p.ovf   = o;
        p.chk_d = cd;
        p.d     = d;
        pr_q.push_back(p);
        pn_q.push_back(nm);
    endtask

    // Ramp (16r+c) or descending (200-16r-c) matrix, with matching expected rows queued.
    task automatic load_ramp(input bit desc, input int nrows);
        logic [IN_BITS-1:0] v [DIM];
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                v[c] = desc ? IN_BITS'(200 - (16 * r + c)) : IN_BITS'(16 * r + c);
                mat[r][c] = v[c];
            end
            if (r < nrows) push_row(pack4(v[0], v[1], v[2], v[3]), r);
        end
    endtask

    task automatic fill_rows(input logic [IN_BITS-1:0] e0, e1, e2, e3);
        for (int r = 0; r < DIM; r++) begin
            mat[r][0] = e0;
            mat[r][1] = e1;
            mat[r][2] = e2;
            mat[r][3] = e3;
        end
    endtask

    // ---------------- monitor / checker ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    probe_t            m_p;
    row_t              m_e;
    string             m_nm;
    bit                m_prev_stall = 1'b0;
    logic [DIM*EW-1:0] m_prev_d;
    logic [RW-1:0]     m_prev_row;

    always @(negedge clk) begin
        if (pr_q.size() > 0) begin
            m_p  = pr_q.pop_front();
            m_nm = pn_q.pop_front();
            chk({m_nm, ".valid"},    128'(out_valid), 128'(m_p.vld));
            chk({m_nm, ".busy"},     128'(busy),      128'(m_p.bsy));
            chk({m_nm, ".row"},      128'(out_row),   128'(m_p.row));
            chk({m_nm, ".last"},     128'(out_last),  128'(m_p.last));
            chk({m_nm, ".overflow"}, 128'(overflow),  128'(m_p.ovf));
            if (m_p.chk_d) chk({m_nm, ".data"}, 128'(out_data), 128'(m_p.d));
        end
        if (!reset && m_prev_stall) begin
            chk("stall_hold_valid", 128'(out_valid), 128'(1'b1));
            chk("stall_hold_data",  128'(out_data),  128'(m_prev_d));
            chk("stall_hold_row",   128'(out_row),   128'(m_prev_row));
        end
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_row: got row %0d data 0x%0h expected no handshake at %0t",
                         out_row, out_data, $time);
            end else begin
                m_e = sb_q.pop_front();
                chk("row_data", 128'(out_data), 128'(m_e.d));
                chk("row_idx",  128'(out_row),  128'(m_e.row));
                chk("row_last", 128'(out_last), 128'(m_e.last));
            end
        end
        m_prev_stall = !reset && out_valid && !out_ready;
        m_prev_d     = out_data;
        m_prev_row   = out_row;
        if (done_req && !mon_done) begin
            chk("rows_all_seen",   128'(sb_q.size()), 128'(0));
            chk("probes_all_seen", 128'(pr_q.size()), 128'(0));
            mon_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        capture      = 1'b0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        shift_amt    = '0;
        mat          = '0;
        tick();
        probe("reset", 0, 0, 0, 0, 0, 1, '0);
        tick();
        reset = 1'b0;
        tick();

        // Basic drain with out_ready held high.
        load_ramp(1'b0, DIM);
        capture   = 1'b1;
        out_ready = 1'b1;
        probe("pre_capture", 0, 0, 0, 0, 0, 0, '0);
        tick();
        capture = 1'b0;
        probe("first_row", 1, 1, 0, 0, 0, 1, pack4(0, 1, 2, 3));
        tick();
        tick();
        probe("row2", 1, 1, 2, 0, 0, 1, pack4(32, 33, 34, 35));
        tick();
        probe("row3_last", 1, 1, 3, 1, 0, 1, pack4(48, 49, 50, 51));
        tick();
        probe("busy_fall", 0, 0, 0, 0, 0, 0, '0);
        tick();

        // Backpressure: ready pattern 1,0,0,1 repeating.
        load_ramp(1'b1, DIM);
        capture   = 1'b1;
        out_ready = 1'b0;
        tick();
        capture = 1'b0;
        for (int i = 0; i < 12; i++) begin
            out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            tick();
        end
        out_ready = 1'b1;
        probe("bp_idle", 0, 0, 0, 0, 0, 0, '0);
        tick();

        // Back-to-back: new capture on the row-3 handshake.
        load_ramp(1'b0, DIM);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        tick();
        tick();
        tick();
        fill_rows(16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA);
        for (int r = 0; r < DIM; r++) push_row(pack4(16'hAA, 16'hAA, 16'hAA, 16'hAA), r);
        capture = 1'b1;
        probe("b2b_last", 1, 1, 3, 1, 0, 0, '0);
        tick();
        capture = 1'b0;
        probe("b2b_row0", 1, 1, 0, 0, 0, 1, pack4(16'hAA, 16'hAA, 16'hAA, 16'hAA));
        tick();
        tick();
        tick();
        tick();
        probe("b2b_idle", 0, 0, 0, 0, 0, 0, '0);
        tick();

        // Drop: capture while row 1 is presented (clear in the same cycle loses to the set).
        load_ramp(1'b0, DIM);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        tick();
        fill_rows(16'h0077, 16'h0077, 16'h0077, 16'h0077);
        capture      = 1'b1;
        overflow_clr = 1'b1;
        probe("drop_row1", 1, 1, 1, 0, 0, 0, '0);
        tick();
        capture      = 1'b0;
        overflow_clr = 1'b0;
        probe("drop_set", 1, 1, 2, 0, 1, 1, pack4(32, 33, 34, 35));
        tick();
        probe("drop_row3", 1, 1, 3, 1, 1, 1, pack4(48, 49, 50, 51));
        tick();
        probe("drop_sticky", 0, 0, 0, 0, 1, 0, '0);
        tick();
        overflow_clr = 1'b1;
        probe("clr_pending", 0, 0, 0, 0, 1, 0, '0);
        tick();
        overflow_clr = 1'b0;
        probe("clr_done", 0, 0, 0, 0, 0, 0, '0);
        tick();

        // Reset mid-stream while row 2 is presented.
        load_ramp(1'b0, 2);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        probe("rst_row2", 1, 1, 2, 0, 0, 0, '0);
        tick();
        #2;
        reset = 1'b1;
        probe("rst_async", 0, 0, 0, 0, 0, 1, '0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            probe("rst_quiet", 0, 0, 0, 0, 0, 0, '0);
            tick();
        end

        // Requantization vectors (pass-through when the feature is off).
        fill_rows(16'h0150, 16'h7FFF, 16'h0003, 16'h0100);
        shift_amt = 5'd4;
        capture   = 1'b1;
        for (int r = 0; r < DIM; r++) begin
`ifdef TAU_DRAIN_REQUANT_EN
            push_row(pack4(16'h15, 16'hFF, 16'h00, 16'h10), r);
`else
            push_row(pack4(16'h0150, 16'h7FFF, 16'h0003, 16'h0100), r);
`endif
        end
        tick();
        capture   = 1'b0;
        shift_amt = 5'd0;
        tick();
        tick();
        tick();
        shift_amt = 5'd20;
        capture   = 1'b1;
        for (int r = 0; r < DIM; r++) begin
`ifdef TAU_DRAIN_REQUANT_EN
            push_row(pack4(16'h00, 16'h00, 16'h00, 16'h00), r);
`else
            push_row(pack4(16'h0150, 16'h7FFF, 16'h0003, 16'h0100), r);
`endif
        end
        tick();
        capture   = 1'b0;
        shift_amt = 5'd0;
        tick();
        tick();
        tick();
        tick();
        probe("final_idle", 0, 0, 0, 0, 0, 0, '0);
        tick();

        done_req = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tau_result_drain.md
Name: tau_result_drain

Overview:
- Sits directly downstream of the tau-MAC GEMM array.
- On the array's finish pulse it snapshots the full DIM x DIM result matrix into a local buffer, freeing the array for the next job.
- It then streams the buffer out one row per handshake over a valid/ready interface, row 0 first.
- An optional requantization stage right-shifts and saturates each element to a narrower width.

Parameters:
- DIM, 16, matrix dimension (rows per job and elements per row).
- IN_BITS, 16, width of each unsigned result element from the MAC array.
- OUT_WIDTH, 8, element width after requantization (used only when the optional feature is enabled).
- SHIFT_BITS, 5, width of the shift-amount port; must satisfy 2^SHIFT_BITS > IN_BITS.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- capture  in  1  single-cycle pulse from the GEMM array's finished output.
- in_mat  in  DIM*DIM*IN_BITS  result matrix, packed [row][col][bit]; sampled only when capture is accepted.
- shift_amt  in  SHIFT_BITS  requantization right-shift; sampled together with in_mat.
- out_valid  out  1  a row is being presented.
- out_ready  in  1  consumer accepts the row.
- out_data  out  DIM*EW  current row, packed [col][bit]; EW = OUT_WIDTH when the feature is enabled, IN_BITS otherwise.
- out_row  out  log2(DIM) (minimum 1)  index of the row on out_data.
- out_last  out  1  high while row DIM-1 is presented.
- busy  out  1  buffer holds an undrained job.
- overflow  out  1  sticky; set when a capture is dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset values: state IDLE; out_valid=0, out_row=0, out_last=0, busy=0, overflow=0. out_data=0 because the snapshot buffer and latched shift are cleared.
- Reset is asynchronous and active-high. Asserting it mid-stream abandons the job immediately; no partial rows are emitted after release.
- FSM states:
  - IDLE: capture=1 -> latch in_mat and shift_amt into the buffer, row counter <= 0, go to STREAM.
  - STREAM: out_valid=1 and busy=1.
    - Handshake (out_valid & out_ready) on row r < DIM-1 -> r <= r+1.
    - Handshake on row DIM-1 -> go to IDLE, unless capture is asserted in the same cycle. In that case latch the new job, reset r to 0 and stay in STREAM (back-to-back, zero bubble).
- Capture in STREAM other than on the last-row handshake: dropped; buffer unchanged; overflow <= 1.
- Capture at the moment the last-row handshake occurs is accepted, not dropped.
- overflow_clr=1 clears overflow. If a drop occurs in the same cycle, the set wins.
- out_data is driven from registered buffer contents selected by the registered row counter; no combinational path from in_mat or capture.
- out_data, out_row and out_last stay stable while out_valid=1 and out_ready=0.
- out_valid never deasserts without a handshake, except on reset.
- Latency: capture in cycle N -> out_valid=1 with row 0 in cycle N+1. One row per cycle when out_ready is held high, so a job drains in DIM cycles.
- busy equals out_valid.
- All arithmetic is unsigned; elements are treated as unsigned IN_BITS values.

Optional Feature:
- Macro: TAU_DRAIN_REQUANT_EN.
- When defined:
  - Each presented element = (elem >> shift_amt), saturated to 2^OUT_WIDTH-1 if the shifted value exceeds it.
  - shift_amt >= IN_BITS yields 0.
  - Requantization is combinational on the buffer read path. It adds no latency and preserves the stability rule.
- When undefined:
  - Elements pass through unmodified at IN_BITS width.
  - shift_amt is ignored and need not be stored.
  - No saturation logic is synthesized.

Test Plan (DIM=4, IN_BITS=16, OUT_WIDTH=8):
- Basic drain: in_mat[r][c]=16*r+c, capture pulse, out_ready held 1 -> four consecutive rows 0..3; row 2 = {32,33,34,35}; out_last only with row 3; busy falls the cycle after the row-3 handshake.
- Backpressure: out_ready toggles 1,0,0,1,... -> each row held stable through the stall cycles; exactly 4 handshakes, no duplicate or skipped rows.
- Back-to-back: second capture with in_mat all 0x00AA asserted in the same cycle as the row-3 handshake -> next cycle shows row 0 = 0x00AA x4; overflow stays 0.
- Drop: capture pulse while row 1 is presented -> original rows 1..3 still emitted; overflow=1 and stays 1 until overflow_clr, which clears it the next cycle.
- Reset mid-stream: assert reset while row 2 is presented -> out_valid, busy, out_row go 0 asynchronously; after release no rows appear until a new capture.
- Requant (TAU_DRAIN_REQUANT_EN): elements 0x0150, 0x7FFF, 0x0003, 0x0100 with shift_amt=4 -> 0x15, 0xFF (saturated), 0x00, 0x10; shift_amt=20 -> all 0.
